// File: rtl/serial_addsub_unit_if.sv
//==============================================================================
// Module   : serial_addsub_unit_if
// Brief    : Request/response bus for the digit-serial add/sub unit.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface serial_addsub_unit_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport slave (
        input  in_valid, op, a, b, acc_clr, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero
    );

    modport master (
        output in_valid, op, a, b, acc_clr, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero
    );
endinterface

`default_nettype wire

// File: rtl/serial_addsub_unit.sv
//==============================================================================
// Module   : serial_addsub_unit
// Brief    : Digit-serial two's-complement add/subtract with accumulator.
// Revision : 1.0
//==============================================================================
`default_nettype none

module serial_addsub_unit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    serial_addsub_unit_if.slave   bus
);
    localparam int IDX_W = $clog2(WIDTH) + 1;
    localparam logic [IDX_W-1:0] c_last_off = IDX_W'(WIDTH - DIGIT);
    localparam logic [IDX_W-1:0] c_step     = IDX_W'(DIGIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_acc;
    logic [IDX_W-1:0] r_off;
    logic             r_cin;
    logic             r_is_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_overflow;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_x_sel;
    logic [DIGIT:0]   w_dsum;
    logic [WIDTH-1:0] w_final;
    logic             w_ovf;

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_last   = (r_off == c_last_off);

    // A same-cycle clear wins over the accumulator contents for ACC ops.
    assign w_x_sel  = bus.op[1] ? (bus.acc_clr ? '0 : r_acc) : bus.a;

    assign w_dsum   = {1'b0, r_x[r_off +: DIGIT]} + {1'b0, r_b[r_off +: DIGIT]}
                    + {{DIGIT{1'b0}}, r_cin};

    always_comb begin
        w_final = r_sum;
        w_final[r_off +: DIGIT] = w_dsum[DIGIT-1:0];
    end

    assign w_ovf = (r_x[WIDTH-1] == r_b[WIDTH-1]) && (w_final[WIDTH-1] != r_x[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_next = S_RUN;
            S_RUN:   if (w_last)        w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_acc      <= '0;
            r_off      <= '0;
            r_cin      <= 1'b0;
            r_is_acc   <= 1'b0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.acc_clr) begin
                        r_acc <= '0;
                    end
                    if (w_accept) begin
                        r_x      <= w_x_sel;
                        r_b      <= bus.op[0] ? ~bus.b : bus.b;
                        r_cin    <= bus.op[0];
                        r_is_acc <= bus.op[1];
                        r_off    <= '0;
                        r_sum    <= '0;
                    end
                end
                S_RUN: begin
                    r_sum <= w_final;
                    r_cin <= w_dsum[DIGIT];
                    r_off <= r_off + c_step;
                    if (w_last) begin
                        r_result   <= w_final;
                        r_carry    <= w_dsum[DIGIT];
                        r_overflow <= w_ovf;
                        r_zero     <= (w_final == '0);
                        if (r_is_acc) begin
                            r_acc <= w_final;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.carry     = r_carry;
    assign bus.overflow  = r_overflow;
    assign bus.zero      = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub_unit.sv
//==============================================================================
// Module   : tb_serial_addsub_unit
// Brief    : Directed self-checking bench for serial_addsub_unit.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_serial_addsub_unit;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_addsub_unit_if #(.WIDTH(16)) m_if ();
    serial_addsub_unit_if #(.WIDTH(16)) s1_if ();
    serial_addsub_unit_if #(.WIDTH(16)) s8_if ();
    serial_addsub_unit_if #(.WIDTH(16)) s16_if ();

    serial_addsub_unit #(.WIDTH(16), .DIGIT(4))  u_dut   (.clk(clk), .rst_n(rst_n), .bus(m_if.slave));
    serial_addsub_unit #(.WIDTH(16), .DIGIT(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(s1_if.slave));
    serial_addsub_unit #(.WIDTH(16), .DIGIT(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(s8_if.slave));
    serial_addsub_unit #(.WIDTH(16), .DIGIT(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(s16_if.slave));

    // The three sweep instances see identical stimulus.
    logic        s_valid;
    logic [1:0]  s_op;
    logic [15:0] s_a;
    logic [15:0] s_b;

    assign s1_if.in_valid  = s_valid;  assign s1_if.op  = s_op;  assign s1_if.a  = s_a;  assign s1_if.b  = s_b;
    assign s1_if.acc_clr   = 1'b0;     assign s1_if.out_ready  = 1'b1;
    assign s8_if.in_valid  = s_valid;  assign s8_if.op  = s_op;  assign s8_if.a  = s_a;  assign s8_if.b  = s_b;
    assign s8_if.acc_clr   = 1'b0;     assign s8_if.out_ready  = 1'b1;
    assign s16_if.in_valid = s_valid;  assign s16_if.op = s_op;  assign s16_if.a = s_a;  assign s16_if.b = s_b;
    assign s16_if.acc_clr  = 1'b0;     assign s16_if.out_ready = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: {carry, overflow, zero, result} from plain integer arithmetic.
    function automatic logic [18:0] model(input logic [1:0] op, input logic [15:0] x,
                                          input logic [15:0] b);
        int          sx, sb, sr;
        logic [16:0] u;
        logic [15:0] r;
        logic        c, o;
        sx = int'($signed(x));
        sb = int'($signed(b));
        if (op[0]) begin
            r  = x - b;
            c  = (x >= b);
            sr = sx - sb;
        end else begin
            u  = {1'b0, x} + {1'b0, b};
            r  = u[15:0];
            c  = u[16];
            sr = sx + sb;
        end
        o = (sr > 32767) || (sr < -32768);
        return {c, o, (r == 16'h0), r};
    endfunction

    function automatic logic [18:0] m_flags();
        return {m_if.carry, m_if.overflow, m_if.zero, m_if.result};
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic clr, output int lat);
        int k;
        k = 0;
        while (!m_if.in_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        m_if.op = op; m_if.a = a; m_if.b = b; m_if.acc_clr = clr; m_if.in_valid = 1'b1;
        @(posedge clk); #1;
        m_if.in_valid = 1'b0; m_if.acc_clr = 1'b0;
        m_if.a = ~a; m_if.b = 16'hA5A5; m_if.op = ~op;
        lat = 0;
        while (!m_if.out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    typedef struct packed { logic [1:0] op; logic [15:0] a; logic [15:0] b; } vec_t;

    initial begin
        int          lat;
        int          bad;
        logic [18:0] held;
        logic [15:0] sacc;
        logic [15:0] x;
        logic [18:0] exp;
        vec_t        vecs [10];
        int          slat [3];
        logic [18:0] sgot [3];
        int          dlat [3];

        n_pass = 0; n_total = 0;
        rst_n = 1'b0;
        m_if.in_valid = 1'b0; m_if.op = 2'b00; m_if.a = '0; m_if.b = '0;
        m_if.acc_clr = 1'b0; m_if.out_ready = 1'b1;
        s_valid = 1'b0; s_op = 2'b00; s_a = '0; s_b = '0;

        #12;
        chk("rst_in_ready",  32'(m_if.in_ready),  32'h1);
        chk("rst_out_valid", 32'(m_if.out_valid), 32'h0);
        chk("rst_flags",     32'(m_flags()),      32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD overflow into sign bit
        do_op(2'b00, 16'h7FFF, 16'h0001, 1'b0, lat);
        chk("add_lat",   32'(lat),       32'd4);
        chk("add_flags", 32'(m_flags()), {13'h0, 1'b0, 1'b1, 1'b0, 16'h8000});
        @(posedge clk); #1;

        do_op(2'b01, 16'h0003, 16'h0005, 1'b0, lat);
        chk("sub_borrow", 32'(m_flags()), {13'h0, 1'b0, 1'b0, 1'b0, 16'hFFFE});
        @(posedge clk); #1;
        do_op(2'b01, 16'h8000, 16'h0001, 1'b0, lat);
        chk("sub_ovf",    32'(m_flags()), {13'h0, 1'b1, 1'b1, 1'b0, 16'h7FFF});
        @(posedge clk); #1;

        // Accumulate sequence
        m_if.acc_clr = 1'b1;
        @(posedge clk); #1;
        m_if.acc_clr = 1'b0;
        do_op(2'b10, 16'hFFFF, 16'h0010, 1'b0, lat);
        chk("acc1", 32'(m_if.result), 32'h0010);
        @(posedge clk); #1;
        do_op(2'b10, 16'hFFFF, 16'h0010, 1'b0, lat);
        chk("acc2", 32'(m_if.result), 32'h0020);
        @(posedge clk); #1;
        do_op(2'b10, 16'h1234, 16'h0010, 1'b0, lat);
        chk("acc3", 32'(m_if.result), 32'h0030);
        @(posedge clk); #1;
        do_op(2'b11, 16'h1234, 16'h0030, 1'b0, lat);
        chk("accsub_zero", 32'(m_flags()), {13'h0, 1'b1, 1'b0, 1'b1, 16'h0000});
        @(posedge clk); #1;
        do_op(2'b10, 16'h0000, 16'h0030, 1'b0, lat);
        chk("acc_after_zero", 32'(m_if.result), 32'h0030);
        @(posedge clk); #1;
        do_op(2'b10, 16'h0000, 16'h0005, 1'b1, lat);
        chk("acc_clr_same", 32'(m_if.result), 32'h0005);
        @(posedge clk); #1;

        // Backpressure: DONE holds, new requests ignored
        m_if.out_ready = 1'b0;
        do_op(2'b00, 16'h1234, 16'h1111, 1'b0, lat);
        chk("bp_result", 32'(m_flags()), {13'h0, 1'b0, 1'b0, 1'b0, 16'h2345});
        held = m_flags();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            m_if.in_valid = 1'b1; m_if.op = 2'(i); m_if.a = 16'(i * 77); m_if.b = 16'h0101;
            @(posedge clk); #1;
            if (!m_if.out_valid || m_if.in_ready || m_flags() !== held) bad++;
        end
        m_if.in_valid = 1'b0;
        chk("bp_stable", 32'(bad), 32'd0);
        m_if.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", 32'(m_if.in_ready),  32'h1);
        chk("bp_release_valid", 32'(m_if.out_valid), 32'h0);
        chk("bp_held_result",   32'(m_if.result),    32'h2345);

        // Reset during the second digit
        m_if.op = 2'b10; m_if.b = 16'h0007; m_if.in_valid = 1'b1;
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(m_if.out_valid), 32'h0);
        chk("midrst_ready", 32'(m_if.in_ready),  32'h1);
        chk("midrst_flags", 32'(m_flags()),      32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_ready", 32'(m_if.in_ready), 32'h1);
        do_op(2'b10, 16'h0000, 16'h0001, 1'b0, lat);
        chk("postrst_acc", 32'(m_if.result), 32'h0001);
        @(posedge clk); #1;

        // DIGIT sweep on shared stimulus
        vecs[0] = '{2'b00, 16'hFFFF, 16'h0001};
        vecs[1] = '{2'b01, 16'h7FFF, 16'hFFFF};
        vecs[2] = '{2'b10, 16'h0000, 16'h4000};
        vecs[3] = '{2'b10, 16'h0000, 16'h4000};
        vecs[4] = '{2'b11, 16'h0000, 16'h0001};
        vecs[5] = '{2'b00, 16'h1357, 16'h2468};
        for (int i = 6; i < 10; i++) begin
            vecs[i] = '{2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom)};
        end
        dlat[0] = 16; dlat[1] = 2; dlat[2] = 1;
        sacc = 16'h0;
        for (int v = 0; v < 10; v++) begin
            x   = vecs[v].op[1] ? sacc : vecs[v].a;
            exp = model(vecs[v].op, x, vecs[v].b);
            if (vecs[v].op[1]) sacc = exp[15:0];
            s_op = vecs[v].op; s_a = vecs[v].a; s_b = vecs[v].b; s_valid = 1'b1;
            @(posedge clk); #1;
            s_valid = 1'b0; s_a = 16'h0F0F; s_b = 16'hF0F0; s_op = ~s_op;
            for (int k = 0; k < 3; k++) begin slat[k] = -1; sgot[k] = '0; end
            for (int e = 1; e <= 20; e++) begin
                @(posedge clk); #1;
                if (s1_if.out_valid && slat[0] < 0) begin
                    slat[0] = e; sgot[0] = {s1_if.carry, s1_if.overflow, s1_if.zero, s1_if.result};
                end
                if (s8_if.out_valid && slat[1] < 0) begin
                    slat[1] = e; sgot[1] = {s8_if.carry, s8_if.overflow, s8_if.zero, s8_if.result};
                end
                if (s16_if.out_valid && slat[2] < 0) begin
                    slat[2] = e; sgot[2] = {s16_if.carry, s16_if.overflow, s16_if.zero, s16_if.result};
                end
            end
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("sweep_lat_d%0d_v%0d", k, v), 32'(slat[k]), 32'(dlat[k]));
                chk($sformatf("sweep_res_d%0d_v%0d", k, v), 32'(sgot[k]), 32'(exp));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/serial_addsub_unit.md
Name: serial_addsub_unit

Overview:
- Parametrised digit-serial two's-complement add/subtract unit with an internal accumulator.
- Successor to the fixed 4-bit combinational add/sub stage: generalised WIDTH, selectable digits per cycle, valid/ready handshakes, status flags and accumulate modes.
- Sits between the register file and any consumer that can tolerate multi-cycle latency, trading area for WIDTH/DIGIT cycles.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- DIGIT, 4, bits processed per clock. WIDTH mod DIGIT must equal 0. N = WIDTH/DIGIT.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/op request valid.
- in_ready  output  1  unit can accept a request.
- op  input  2  operation: 00 ADD a+b; 01 SUB a-b; 10 ACC_ADD acc+b; 11 ACC_SUB acc-b.
- a  input  WIDTH  operand A; ignored for ACC ops.
- b  input  WIDTH  operand B.
- acc_clr  input  1  clear accumulator.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference.
- carry  output  1  carry out of the MSB. For SUB ops, 1 = no borrow.
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0.
  - result, carry, overflow, zero=0.
  - Accumulator, digit counter and internal carry=0.
- State IDLE:
  - in_ready=1.
  - Accept on in_valid & in_ready at edge E0: latch operand X, B' and the initial carry, then go to RUN.
    - X = a for ADD/SUB; X = accumulator for ACC ops.
    - B' = b for ADD/ACC_ADD; B' = ~b for SUB/ACC_SUB.
    - Initial carry = op[0].
  - acc_clr is sampled only in IDLE.
  - If acc_clr and an ACC request coincide, the clear applies first, so X = 0.
- State RUN:
  - in_ready=0.
  - At edge E0+1+i (i = 0..N-1), add digit i (LSB digit first): X[i*DIGIT +: DIGIT] + B'[same] + carry. Store the sum digit and propagate the carry.
  - Latency: at edge E0+N, the final digit completes and the state goes to DONE.
  - At the same edge: out_valid=1; result, carry and zero are registered.
  - overflow = (X[MSB] == B'[MSB]) & (result[MSB] != X[MSB]).
  - For ACC ops, the accumulator is loaded with result at the same edge.
- State DONE:
  - out_valid=1; outputs held stable; in_ready=0. in_valid and acc_clr are ignored.
  - On out_valid & out_ready: out_valid=0 and the state returns to IDLE on the next edge.
  - result and the flags keep their last values until the next completion.
- Throughput: one request per N+2 cycles when out_ready is tied high.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - The carry is the true carry out of bit WIDTH-1.
  - The internal digit adder is DIGIT+1 bits wide.
- Boundary conditions:
  - DIGIT = WIDTH gives N = 1: one RUN cycle, and out_valid rises at E0+1.
  - DIGIT = 1 gives a pure bit-serial unit.
  - Reset asserted mid-RUN or in DONE aborts the operation. All state and the accumulator return to reset values. No partial result is ever presented.
  - The inputs a, b and op may change after the accept edge without affecting the in-flight operation.

Test Plan:
Use WIDTH=16, DIGIT=4 (N=4) unless stated otherwise.
1. ADD a=0x7FFF, b=0x0001 -> out_valid rises exactly 4 edges after accept; result=0x8000, carry=0, overflow=1, zero=0.
2. SUB a=0x0003, b=0x0005 -> result=0xFFFE, carry=0 (borrow), overflow=0. Then SUB a=0x8000, b=0x0001 -> result=0x7FFF, carry=1, overflow=1.
3. Accumulate sequence: acc_clr in IDLE, then ACC_ADD b=0x0010 three times -> results 0x0010, 0x0020, 0x0030. Then ACC_SUB b=0x0030 -> result=0x0000, zero=1, carry=1. Separately, ACC_ADD b=0x0005 issued with acc_clr in the same cycle -> result=0x0005.
4. Backpressure: hold out_ready=0 for 10 cycles after completion -> out_valid, result and flags stay stable; in_ready=0; in_valid pulses are not accepted. Releasing out_ready -> in_ready=1 on the next cycle.
5. Reset mid-RUN: assert rst_n=0 during the second digit -> outputs immediately return to reset values. After release, in_ready=1, and ACC_ADD b=0x0001 yields 0x0001 (accumulator cleared).
6. Parameter sweep with WIDTH=16 at DIGIT=1, 8 and 16: use random a/b/op compared against a reference model. Latency must equal 16, 2 and 1 cycles respectively, with all flags matching the model.
